// File: rtl/imem_loader_if.sv
// Byte-stream load port and IMEM write port of the instruction-memory loader.
// master = host side driving the stream; slave = the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = ADDR_W + 1
);
  logic             LD_start;
  logic [CNT_W-1:0] LD_word_count;
  logic [7:0]       LD_byte;
  logic             LD_byte_valid;
  logic             LD_byte_ready;
  logic             IMEM_wr_en;
  logic [31:0]      IMEM_wr_addr;
  logic [31:0]      IMEM_wr_data;
  logic             LD_busy;
  logic             LD_done;
  logic             LD_error;

  modport master (
    output LD_start, LD_word_count, LD_byte, LD_byte_valid,
    input  LD_byte_ready, IMEM_wr_en, IMEM_wr_addr, IMEM_wr_data,
           LD_busy, LD_done, LD_error
  );

  modport slave (
    input  LD_start, LD_word_count, LD_byte, LD_byte_valid,
    output LD_byte_ready, IMEM_wr_en, IMEM_wr_addr, IMEM_wr_data,
           LD_busy, LD_done, LD_error
  );
endinterface

// File: rtl/imem_loader.sv
// IMEM loader: packs a byte stream into big-endian words written at 4*idx; write strobe 1 cycle after 4th byte, >=5 cycles/word,
// ready low outside RECV/CHECK. All state on the falling edge of SYS_clk. LD_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = ADDR_W + 1
) (
  input logic          SYS_clk,
  input logic          SYS_reset,
  imem_loader_if.slave ld
);

  localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

`ifdef LD_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_q;
`ifdef LD_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic        byte_rdy_q;
  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic xfer;
  logic last_word;
  logic count_over;

  assign xfer       = ld.LD_byte_valid && byte_rdy_q;
  assign last_word  = (CNT_W'(word_idx) == (count_q - CNT_W'(1)));
  assign count_over = (32'(ld.LD_word_count) > CAPACITY);

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state      <= S_IDLE;
      count_q    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
`ifdef LD_CHECKSUM_EN
      csum_q     <= '0;
`endif
      byte_rdy_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld.LD_start) begin
            if (ld.LD_word_count == '0) begin
              done_q <= 1'b1;
            end else if (count_over) begin
              err_q <= 1'b1;
            end else begin
              count_q    <= ld.LD_word_count;
              word_idx   <= '0;
              byte_idx   <= '0;
`ifdef LD_CHECKSUM_EN
              csum_q     <= '0;
`endif
              err_q      <= 1'b0;
              byte_rdy_q <= 1'b1;
              busy_q     <= 1'b1;
              state      <= S_RECV;
            end
          end
        end

        S_RECV: begin
          if (xfer) begin
`ifdef LD_CHECKSUM_EN
            csum_q <= csum_q + ld.LD_byte;
`endif
            // First three bytes shift through asm_q; the fourth completes the word directly.
            if (byte_idx == 2'd3) begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= 32'({word_idx, 2'b00});
              wr_data_q  <= {asm_q, ld.LD_byte};
              byte_rdy_q <= 1'b0;
              state      <= S_WRITE;
            end else begin
              asm_q    <= {asm_q[15:0], ld.LD_byte};
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        S_WRITE: begin
          word_idx <= word_idx + ADDR_W'(1);
          if (last_word) begin
`ifdef LD_CHECKSUM_EN
            byte_rdy_q <= 1'b1;
            state      <= S_CHECK;
`else
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
`endif
          end else begin
            byte_idx   <= '0;
            byte_rdy_q <= 1'b1;
            state      <= S_RECV;
          end
        end

`ifdef LD_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            if (ld.LD_byte != csum_q) err_q <= 1'b1;
            byte_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state      <= S_DONE;
          end
        end
`endif

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ld.LD_byte_ready = byte_rdy_q;
  assign ld.IMEM_wr_en    = wr_en_q;
  assign ld.IMEM_wr_addr  = wr_addr_q;
  assign ld.IMEM_wr_data  = wr_data_q;
  assign ld.LD_busy       = busy_q;
  assign ld.LD_done       = done_q;
  assign ld.LD_error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed loads with random bytes/gaps, checked against a word-list model.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = ADDR_W + 1;

  logic SYS_clk = 1'b0;
  logic SYS_reset;
  always #5 SYS_clk = ~SYS_clk;

  imem_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) ld ();
  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .SYS_clk  (SYS_clk),
    .SYS_reset(SYS_reset),
    .ld       (ld)
  );

  int checks = 0;
  int errors = 0;

  // Write/done monitor, sampled on the rising edge (DUT moves on the falling edge).
  logic [63:0] wr_q[$];
  int cyc = 0, last_wr_cyc = 0, done_cyc = 0, done_cnt = 0;
  always @(posedge SYS_clk) begin
    cyc++;
    if (ld.IMEM_wr_en) begin
      wr_q.push_back({ld.IMEM_wr_addr, ld.IMEM_wr_data});
      last_wr_cyc = cyc;
    end
    if (ld.LD_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  logic [31:0] words[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge SYS_clk);
    ld.LD_word_count = CNT_W'(n);
    ld.LD_start      = 1'b1;
    @(posedge SYS_clk);
    ld.LD_start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc, ok;
    int n;
    repeat (gap) @(posedge SYS_clk);
    ld.LD_byte       = b;
    ld.LD_byte_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      acc = ld.LD_byte_ready;
      @(posedge SYS_clk);
      ok = acc;
      n++;
    end
    ld.LD_byte_valid = 1'b0;
    ld.LD_byte       = 8'($urandom);
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(negedge SYS_clk);
      n++;
    end
    #1;
    check("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  // Loads `words`; the model expects word i at byte address 4*i.
  task automatic run_load(input int gapmax, input bit poke, input logic [7:0] csum_xor);
    int n;
    int d0;
    int sum;
    logic [7:0] b;
    n   = words.size();
    sum = 0;
    wr_q.delete();
    d0 = done_cnt;
    pulse_start(n);
    ld.LD_word_count = CNT_W'($urandom);
    check("busy_after_start", 32'(ld.LD_busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][31-8*k -: 8];
        sum = (sum + int'(b)) % 256;
        send_byte(b, $urandom_range(0, gapmax));
      end
      if (poke && i == 0) pulse_start(9);
    end
`ifdef LD_CHECKSUM_EN
    send_byte(8'(sum) ^ csum_xor, $urandom_range(0, gapmax));
`endif
    wait_done(d0);
    check("busy_after_done", 32'(ld.LD_busy), 32'd0);
    check("write_count", 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check("wr_addr", wr_q[i][63:32], 32'(i * 4));
      check("wr_data", wr_q[i][31:0], words[i]);
    end
`ifdef LD_CHECKSUM_EN
    check("csum_error", 32'(ld.LD_error), 32'(csum_xor != 8'd0));
`else
    check("done_after_last_write", 32'(done_cyc), 32'(last_wr_cyc + 1));
    check("error_clear", 32'(ld.LD_error), 32'd0);
`endif
  endtask

  initial begin
    int d0;
    SYS_reset        = 1'b1;
    ld.LD_start      = 1'b0;
    ld.LD_word_count = '0;
    ld.LD_byte       = '0;
    ld.LD_byte_valid = 1'b0;
    repeat (3) @(posedge SYS_clk);
    check("rst_ready", 32'(ld.LD_byte_ready), 32'd0);
    check("rst_wr_en", 32'(ld.IMEM_wr_en), 32'd0);
    check("rst_busy", 32'(ld.LD_busy), 32'd0);
    check("rst_done", 32'(ld.LD_done), 32'd0);
    check("rst_error", 32'(ld.LD_error), 32'd0);
    SYS_reset = 1'b0;

    // Single word, valid held high.
    words = '{32'h20080005};
    run_load(0, 1'b0, 8'h00);

    // Three words with gapped valid.
    words = '{32'h01095020, 32'h8C0A0004, 32'hAC0B0008};
    run_load(3, 1'b0, 8'h00);

    // Zero count: done pulse, no writes.
    wr_q.delete();
    d0 = done_cnt;
    pulse_start(0);
    repeat (4) @(posedge SYS_clk);
    check("zero_done", 32'(done_cnt - d0), 32'd1);
    check("zero_writes", 32'(wr_q.size()), 32'd0);

    // Over-range count.
    pulse_start((1 << ADDR_W) + 1);
    check("over_busy", 32'(ld.LD_busy), 32'd0);
    repeat (4) @(posedge SYS_clk);
    check("over_error", 32'(ld.LD_error), 32'd1);
    check("over_ready", 32'(ld.LD_byte_ready), 32'd0);
    check("over_writes", 32'(wr_q.size()), 32'd0);

    // Random load; also clears the sticky error.
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back($urandom);
    run_load(2, 1'b0, 8'h00);

    // Reset partway through the second word of a 4-word load.
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    wr_q.delete();
    pulse_start(4);
    for (int k = 0; k < 6; k++) send_byte(words[k/4][31-8*(k%4) -: 8], 0);
    #2 SYS_reset = 1'b1;
    #1;
    check("arst_ready", 32'(ld.LD_byte_ready), 32'd0);
    check("arst_wr_en", 32'(ld.IMEM_wr_en), 32'd0);
    check("arst_addr", ld.IMEM_wr_addr, 32'd0);
    check("arst_data", ld.IMEM_wr_data, 32'd0);
    check("arst_busy", 32'(ld.LD_busy), 32'd0);
    @(posedge SYS_clk);
    SYS_reset = 1'b0;
    ld.LD_byte_valid = 1'b1;
    repeat (8) @(posedge SYS_clk);
    ld.LD_byte_valid = 1'b0;
    check("arst_writes", 32'(wr_q.size()), 32'd1);
    words = '{32'hCAFEF00D};
    run_load(1, 1'b0, 8'h00);

    // LD_start while busy is ignored.
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    run_load(1, 1'b1, 8'h00);

`ifdef LD_CHECKSUM_EN
    words = '{32'h01020304};
    run_load(0, 1'b0, 8'h00);
    run_load(0, 1'b0, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The fetch stage only reads IMEM; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into 32-bit big-endian words.
- Writes each word to IMEM at consecutive word-aligned addresses starting at 0.
- Holds `LD_busy` high while loading so the top level keeps the pipeline in reset until the program is in place.

Parameters:
- ADDR_W, 8, IMEM word-address width; capacity = 2^ADDR_W words.
- CNT_W, ADDR_W+1, width of the word-count input, so a full memory is expressible.

Ports:
- SYS_clk  in  1  system clock; all state updates on the falling edge, same as the pipeline registers.
- SYS_reset  in  1  asynchronous, active-high reset.
- LD_start  in  1  begin a load; sampled only in IDLE.
- LD_word_count  in  CNT_W  number of words to load; latched on the start edge.
- LD_byte  in  8  stream byte.
- LD_byte_valid  in  1  LD_byte is valid.
- LD_byte_ready  out  1  loader can accept a byte.
- IMEM_wr_en  out  1  IMEM write strobe, one cycle per word.
- IMEM_wr_addr  out  32  byte address = word_idx*4; bits [1:0] always 0.
- IMEM_wr_data  out  32  assembled word.
- LD_busy  out  1  load in progress.
- LD_done  out  1  one-cycle pulse on completion.
- LD_error  out  1  sticky error flag; cleared by the next accepted LD_start or by reset.

Behaviour:
- Reset (async, any state): FSM→IDLE; clears word_idx, byte_idx, assembly register, count and checksum.
  - All outputs go to 0. A partial word is discarded; nothing is written.
- States: IDLE, RECV, WRITE, CHECK (only with the optional feature), DONE.
- IDLE:
  - LD_byte_ready=0, LD_busy=0.
  - On LD_start:
    - count==0 → LD_done pulses next cycle, stay IDLE, no writes.
    - count > 2^ADDR_W → LD_error=1, stay IDLE.
    - otherwise → latch count, clear indices and LD_error, go to RECV.
- RECV:
  - LD_byte_ready=1, LD_busy=1.
  - A byte transfers on an edge where valid&&ready.
  - Assembly is big-endian: first byte lands in [31:24], fourth in [7:0]. byte_idx increments 0..3.
  - The transfer with byte_idx==3 goes to WRITE. No byte is consumed without valid.
- WRITE (exactly one cycle):
  - LD_byte_ready=0, IMEM_wr_en=1, IMEM_wr_addr={word_idx,2'b00} zero-extended, IMEM_wr_data=assembled word.
  - Next: word_idx++. If this was word count-1 → CHECK (feature on) or DONE; else → RECV with byte_idx=0.
- DONE: LD_done=1 for one cycle, LD_busy=0, → IDLE.
- LD_busy is 1 in RECV, WRITE and CHECK only.
- Latency and throughput:
  - Write strobe appears the cycle after the 4th byte is accepted.
  - Minimum 5 cycles per word.
  - LD_done arrives 1 cycle after the last write (feature off).
- LD_start while busy is ignored. LD_word_count changes after start have no effect.
- Address wrap is impossible: count is bounded by the IDLE check, so word_idx never exceeds 2^ADDR_W-1.
- IMEM_wr_data/addr are don't-care when IMEM_wr_en=0. They are held at the last written value.

Optional Feature:
- Macro: LD_CHECKSUM_EN.
- When defined:
  - An 8-bit running sum (mod 256) of every data byte is kept.
  - After the last WRITE the FSM enters CHECK with LD_byte_ready=1 and accepts one extra byte.
  - If it differs from the sum, LD_error=1. Either way → DONE.
  - Words are still written regardless of the result.
- When undefined:
  - No CHECK state, no checksum byte expected.
  - LD_error is raised only by an over-range count.

Test Plan:
- Reset, start count=1, bytes 20,08,00,05 with valid held high → one IMEM_wr_en pulse, addr 0x00000000, data 0x20080005; LD_done 1 cycle later; LD_busy low after.
- count=3, bytes for 0x01095020, 0x8C0A0004, 0xAC0B0008 with valid gapped by random 0-3 idle cycles → writes at 0x0, 0x4, 0x8 with those data; no byte accepted while valid=0.
- count=0 → LD_done pulses, no IMEM_wr_en. count=2^ADDR_W+1 (257) → LD_error=1, no writes, LD_busy stays 0.
- Assert SYS_reset after 2 bytes of the 2nd word of a count=4 load → outputs 0 immediately, no further writes; a fresh start count=1 then loads correctly at address 0.
- LD_start pulsed mid-load with count=9 → ignored; original count honoured (number of writes = original count).
- LD_CHECKSUM_EN, count=1, bytes 01,02,03,04 then checksum 0x0A → LD_error=0. Repeat with 0x0B → LD_error=1; word 0x01020304 still written.
